// File: rtl/tt_um_qif_neuron.sv
// Quadratic integrate-and-fire neuron.
// Each clock edge the membrane potential V integrates its own scaled square
// plus the input current B. When the sum reaches V_PEAK the neuron fires:
// V returns to V_RESET and spike_out pulses high for exactly one cycle.
// The only state is V and spike_out; both outputs come straight from flops.
module tt_um_qif_neuron #(
   parameter int unsigned V_PEAK  = 200,  // spike threshold, 1..255
   parameter int unsigned V_RESET = 0,    // post-spike / reset value, < V_PEAK
   parameter int unsigned SHIFT   = 6     // quadratic gain 2^-SHIFT, 0..15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] B,
   output logic [7:0] V,
   output logic       spike_out
);

   localparam logic [7:0]  VRESET_C = V_RESET[7:0];
   localparam logic [16:0] VPEAK_C  = 17'(V_PEAK);

   logic [7:0]  v_q;
   logic [7:0]  v_d;
   logic        spike_q;
   logic        spike_d;
   logic [15:0] prod_s;
   logic [15:0] sq_s;
   logic [16:0] sum_s;

   // Integration datapath and threshold decision for the next potential.
   always_comb begin
      // Full 16-bit product is formed before shifting so no bits are lost.
      prod_s  = 16'(v_q) * 16'(v_q);
      sq_s    = prod_s >> SHIFT;
      // 17 bits hold 255 + 65535 + 255 without wrapping.
      sum_s   = 17'(v_q) + 17'(sq_s) + 17'(B);
      v_d     = VRESET_C;
      spike_d = 1'b0;
      if (sum_s >= VPEAK_C) begin
         // Equality counts as a crossing.
         v_d     = VRESET_C;
         spike_d = 1'b1;
      end else begin
         // sum < V_PEAK <= 255 here, so the low byte is exact.
         v_d     = sum_s[7:0];
         spike_d = 1'b0;
      end
   end

   // State register; reset wins over any spike on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q     <= VRESET_C;
         spike_q <= 1'b0;
      end else begin
         v_q     <= v_d;
         spike_q <= spike_d;
      end
   end

   assign V         = v_q;
   assign spike_out = spike_q;

endmodule

// File: tb/tb_tt_um_qif_neuron.sv
// Self-checking bench for tt_um_qif_neuron at default parameters.
// Directed scenarios use fixed expected sequences; a randomized run is
// compared against an arithmetic reference model of the neuron.
module tb_tt_um_qif_neuron;

   logic       clk;
   logic       rst;
   logic [7:0] B;
   logic [7:0] V;
   logic       spike_out;

   int checks;
   int errors;

   // Reference model state (plain integers)
   int m_v;
   int m_spike;

   tt_um_qif_neuron dut (
      .clk      (clk),
      .rst      (rst),
      .B        (B),
      .V        (V),
      .spike_out(spike_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: V' = V + floor(V^2/64) + B; fire at >= 200.
   function automatic void model_step(input int b, input bit r);
      int s;
      if (r) begin
         m_v     = 0;
         m_spike = 0;
      end else begin
         s = m_v + (m_v * m_v) / 64 + b;
         if (s >= 200) begin
            m_v     = 0;
            m_spike = 1;
         end else begin
            m_v     = s;
            m_spike = 0;
         end
      end
   endfunction

   // Apply inputs, take one rising edge, sample 1 ns later, advance the model.
   task automatic step(input int b, input bit r);
      B   = 8'(b);
      rst = r;
      @(posedge clk);
      #1;
      model_step(b, r);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         step(255, 1'b1);
         checks++;
         if (V !== 8'd0 || spike_out !== 1'b0) begin
            errors++;
            $display("FAIL reset edge %0d: V=%0d spike=%b, want V=0 spike=0", i, V, spike_out);
         end
      end
   endtask

   task automatic test_quiescent();
      step(0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         step(0, 1'b0);
         checks++;
         if (V !== 8'd0 || spike_out !== 1'b0) begin
            errors++;
            $display("FAIL quiescent edge %0d: V=%0d spike=%b, want V=0 spike=0", i, V, spike_out);
         end
      end
   endtask

   task automatic test_ramp();
      int exp_v[8]  = '{10, 21, 37, 68, 150, 0, 10, 21};
      int exp_sp[8] = '{0, 0, 0, 0, 0, 1, 0, 0};
      step(0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(10, 1'b0);
         checks++;
         if (V !== 8'(exp_v[i]) || spike_out !== 1'(exp_sp[i])) begin
            errors++;
            $display("FAIL ramp edge %0d: V=%0d spike=%b, want V=%0d spike=%0d",
                     i + 1, V, spike_out, exp_v[i], exp_sp[i]);
         end
      end
   endtask

   task automatic test_threshold_eq();
      step(0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step(200, 1'b0);
         checks++;
         if (V !== 8'd0 || spike_out !== 1'b1) begin
            errors++;
            $display("FAIL threshold_eq edge %0d: V=%0d spike=%b, want V=0 spike=1", i, V, spike_out);
         end
      end
   endtask

   task automatic test_near_threshold();
      logic [7:0] ev;
      logic       es;
      step(0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         step(199, 1'b0);
         ev = (i % 2 == 0) ? 8'd199 : 8'd0;
         es = (i % 2 == 0) ? 1'b0 : 1'b1;
         checks++;
         if (V !== ev || spike_out !== es) begin
            errors++;
            $display("FAIL near_threshold edge %0d: V=%0d spike=%b, want V=%0d spike=%b",
                     i, V, spike_out, ev, es);
         end
      end
   endtask

   task automatic test_reset_mid();
      step(0, 1'b1);
      for (int i = 0; i < 4; i++) step(10, 1'b0);
      checks++;
      if (V !== 8'd68) begin
         errors++;
         $display("FAIL reset_mid pre: V=%0d, want 68", V);
      end
      step(10, 1'b1);
      checks++;
      if (V !== 8'd0 || spike_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid rst: V=%0d spike=%b, want V=0 spike=0", V, spike_out);
      end
      step(10, 1'b0);
      checks++;
      if (V !== 8'd10 || spike_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid resume: V=%0d spike=%b, want V=10 spike=0", V, spike_out);
      end
   endtask

   task automatic test_reset_suppress();
      step(0, 1'b1);
      for (int i = 0; i < 5; i++) step(10, 1'b0);
      checks++;
      if (V !== 8'd150) begin
         errors++;
         $display("FAIL reset_suppress pre: V=%0d, want 150", V);
      end
      step(10, 1'b1);
      checks++;
      if (V !== 8'd0 || spike_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_suppress rst: V=%0d spike=%b, want V=0 spike=0", V, spike_out);
      end
   endtask

   task automatic test_random();
      int b;
      bit r;
      step(0, 1'b1);
      for (int i = 0; i < 400; i++) begin
         // Mix small currents (long ramps) with large ones (frequent spikes).
         b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                          : int'($urandom_range(0, 40));
         r = ($urandom_range(0, 31) == 0);
         step(b, r);
         checks++;
         if (V !== 8'(m_v) || spike_out !== 1'(m_spike)) begin
            errors++;
            $display("FAIL random cycle %0d (B=%0d rst=%b): V=%0d spike=%b, want V=%0d spike=%0d",
                     i, b, r, V, spike_out, m_v, m_spike);
         end
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      m_v     = 0;
      m_spike = 0;
      rst     = 1'b1;
      B       = 8'd0;
      test_reset();
      test_quiescent();
      test_ramp();
      test_threshold_eq();
      test_near_threshold();
      test_reset_mid();
      test_reset_suppress();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tt_um_qif_neuron.md
TT_UM_QIF_NEURON -- requirements
Module: tt_um_qif_neuron

Interface
REQ-001 Parameter V_PEAK, default 200: spike threshold; the legal range SHALL be 1..255.
REQ-002 Parameter V_RESET, default 0: post-spike and reset value of V; it SHALL be less than V_PEAK.
REQ-003 Parameter SHIFT, default 6: right-shift applied to V*V (quadratic gain 2^-SHIFT); the legal range SHALL be 0..15.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 B  input  8  unsigned input current, sampled every rising clock edge.
REQ-007 V  output  8  unsigned membrane potential, driven directly from a register.
REQ-008 spike_out  output  1  spike flag, driven directly from a register.

Function
REQ-009 On each rising edge with rst=0, the block SHALL compute sq = (V*V) >> SHIFT from the full 16-bit unsigned product, with no truncation before the shift.
REQ-010 The block SHALL compute sum = V + sq + B unsigned in at least 17 bits, with no overflow or wrap.
REQ-011 If sum >= V_PEAK, then on the same edge the block SHALL set V <= V_RESET and spike_out <= 1.
REQ-012 Otherwise the block SHALL set V <= sum[7:0], which is exact because sum < V_PEAK <= 255, and spike_out <= 0.
REQ-013 spike_out SHALL be a one-cycle pulse per threshold crossing, coincident with the cycle in which V shows V_RESET.
REQ-014 Latency: B SHALL affect V and spike_out on the first rising edge after it is applied; there SHALL be no further pipelining.
REQ-015 Consecutive spikes SHALL be allowed on every cycle, e.g. when V_RESET + sq(V_RESET) + B >= V_PEAK.
REQ-016 With B=0 and V=0, V SHALL remain 0; this is a fixed point.
REQ-017 Equality sum == V_PEAK SHALL count as a spike.
REQ-018 The block SHALL contain no saturation logic, no leak term, no refractory period and no other state beyond V and spike_out.

Reset
REQ-019 On a rising edge with rst=1, the block SHALL set V <= V_RESET and spike_out <= 0, regardless of B or the current V.
REQ-020 rst SHALL take priority over spike generation, including when a spike would have occurred on the same edge.
REQ-021 After rst deasserts, integration SHALL resume from V_RESET on the next edge.
REQ-022 Before the first reset, output values are undefined, and the bench SHALL apply reset first.

Verification (default parameters)
REQ-023 Reset: rst=1 for 2 edges, with B=255 -> V=0 and spike_out=0 after each edge.
REQ-024 Quiescent: after reset, B=0 for 20 edges -> V=0 and spike_out=0 throughout.
REQ-025 Quadratic ramp: after reset, B=10 -> V over successive edges SHALL be 10, 21, 37, 68, 150, 0.
- On the 6th edge spike_out=1; it is 0 on edges 1-5.
- The sequence then repeats: 10, 21, ...
REQ-026 Threshold equality: after reset, B=200 -> V=0 and spike_out=1 on every edge.
REQ-027 Near-threshold: after reset, B=199 -> V alternates 199 (spike 0) and 0 (spike 1).
- The 0 value follows from sq = 618, giving sum = 1016 >= 200.
REQ-028 Reset mid-operation: B=10 ramp up to V=68, then rst=1 for one edge.
- On that edge: V=0 and spike_out=0.
- After rst=0: V=10 on the next edge.
REQ-029 Reset suppressing a spike: B=10 ramp up to V=150, then rst=1 on the edge that would spike.
- On that edge: V=0 and spike_out=0.
